i2s_adc_rx: RTL

- Front-end stage of the audio path: deserialises the external ADC's I2S stream into parallel 24-bit samples.
- Produces one `signal` word plus a one-cycle `signal_en` strobe per frame for the selected channel.
- Output feeds the sample shift-window directly, so `signal_en` is the window's shift enable.
- All I2S pins are asynchronous to `clk`; they are synchronised internally, and the block runs entirely on `clk`.

---
 rtl/i2s_adc_rx_pkg.sv | 12 +
 rtl/i2s_adc_rx_sync_edge.sv | 22 ++
 rtl/i2s_adc_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/i2s_adc_rx_pkg.sv
// Shared types and defaults for the I2S ADC receiver.
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int CNT_W      = $clog2(SLOT_W_DEF + 1);

  function automatic int cnt_w(input int slot_w);
    return $clog2(slot_w + 1);
  endfunction
endpackage

// File: rtl/i2s_adc_rx_sync_edge.sv
// Two-flop synchroniser with a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
    end
  end
endmodule

// File: rtl/i2s_adc_rx.sv
// I2S receiver: captures one DATA_W-bit word per frame from the selected channel.
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int CHANNEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  output logic [DATA_W-1:0] signal,
  output logic              signal_en,
  output logic              frame_err,
  output logic              busy
);
  localparam int   CW = cnt_w(SLOT_W);
  localparam logic CH = 1'(CHANNEL);

  logic          sck_rise;
  logic [1:0]    ws_sync, sd_sync;
  logic          ws_s, sd_s;
  logic          ws_prev, ws_seen;
  logic          start;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [DATA_W-2:0] shreg;

  sync_edge u_sck (.clk(clk), .reset(reset), .din(sck_i), .rise(sck_rise));

  // The registered edge pulse lags the raw sync by one clk; WS/SD are stable
  // for half an SCK period around the rising edge, so no extra align stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_sync <= '0;
      sd_sync <= '0;
    end else begin
      ws_sync <= {ws_sync[0], ws_i};
      sd_sync <= {sd_sync[0], sd_i};
    end
  end

  assign ws_s  = ws_sync[1];
  assign sd_s  = sd_sync[1];
  // ws_seen blocks a start on the very first sampled WS (no observed transition).
  assign start = ws_seen && (ws_s != ws_prev) && (ws_s == CH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      signal    <= '0;
      signal_en <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      ws_prev   <= 1'b0;
      ws_seen   <= 1'b0;
    end else begin
      signal_en <= 1'b0;
      frame_err <= 1'b0;
      if (sck_rise) begin
        ws_prev <= ws_s;
        ws_seen <= 1'b1;
        case (state)
          IDLE: if (start) begin
            state <= DELAY;
            busy  <= 1'b1;
          end
          DELAY: begin
            shreg    <= '0;
            shreg[0] <= sd_s;
            cnt      <= CW'(1);
            state    <= SHIFT;
          end
          SHIFT: begin
            if (ws_s != ws_prev) begin
              // Truncated word; the same WS edge may already start a new one.
              frame_err <= 1'b1;
              shreg     <= '0;
              cnt       <= '0;
              state     <= start ? DELAY : IDLE;
              busy      <= start;
            end else begin
              shreg <= {shreg[DATA_W-3:0], sd_s};
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(DATA_W - 1)) begin
                signal    <= {shreg, sd_s};
                signal_en <= 1'b1;
                state     <= PAD;
                busy      <= 1'b0;
              end
            end
          end
          PAD: if (ws_s != CH) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
